fir_mac_alu: RTL and testbench
==============================

// Module: fir_mac_alu
// PURPOSE
//  Parametrised, pipelined signed arithmetic unit for the FIR core. Successor to the fixed
//  16x16->32 add/multiply ALU: adds valid/ready handshaking, a multiply-accumulate mode with
//  a guard-bit accumulator, and output scaling with optional saturation. Sits between the
//  sample/coefficient fetch logic and the output sample buffer.
// PARAMETERS
//  DATA_W     16  width of signed operands a, b
//  ACC_W      40  accumulator width (2*DATA_W + guard bits); must be >= 2*DATA_W
//  OUT_W      32  width of signed result
//  OUT_SHIFT  0   arithmetic right shift applied to result before saturation (0..ACC_W-OUT_W)
//  SAT_EN     1   1: saturate to OUT_W signed range; 0: truncate to low OUT_W bits
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       block can accept a beat this cycle
//  a          in   DATA_W  signed operand (sample)
//  b          in   DATA_W  signed operand (coefficient)
//  op_sel     in   2       00 ADD, 01 MUL, 10 MAC, 11 SUB
//  in_last    in   1       MAC only: final term of the dot product; emit result and clear acc
//  out_valid  out  1       result beat valid
//  out_ready  in   1       downstream accepts result
//  result     out  OUT_W   signed result
//  out_sat    out  1       result was clipped (SAT_EN=1) or truncated with loss (SAT_EN=0)
// BEHAVIOUR
//  - Reset: out_valid=0, result=0, out_sat=0, acc=0, all stage valids=0. in_ready=1 after reset.
//    Reset mid-MAC discards the partial sum; no output beat is produced for it.
//  - Beat accepted when in_valid && in_ready. 2-stage pipeline: S1 registers op, last and the
//    full-precision term (a+b, a-b or a*b, sign-extended to ACC_W); S2 forms the ACC_W sum,
//    shifts, saturates/truncates and registers result. Latency: accept in cycle N -> out_valid
//    at cycle N+2.
//  - Stall: stall = out_valid && !out_ready. in_ready = !stall. While stalled, S1, S2, acc,
//    result and out_sat hold; result/out_sat stay stable until the beat is taken.
//  - Throughput: one beat per cycle when out_ready stays high.
//  - ADD/SUB/MUL: result = scale(term); one output beat per input beat; acc untouched.
//  - MAC, in_last=0: acc <= acc + term (wraps modulo 2^ACC_W); NO output beat.
//  - MAC, in_last=1: output = scale(acc + term); acc <= 0 in the same cycle, so the next MAC
//    beat starts a fresh sum. in_last is ignored for non-MAC ops.
//  - ADD/SUB/MUL beats may interleave with an open MAC sum; they do not alter acc.
//  - scale(x): y = x >>> OUT_SHIFT. SAT_EN=1: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and set
//    out_sat=1 when clipped. SAT_EN=0: take y[OUT_W-1:0], and set out_sat=1 when the
//    discarded bits are not a sign extension of the kept bits.
//  - Arithmetic is fully signed (two's complement). -2^(DATA_W-1) * -2^(DATA_W-1) is exact
//    at ACC_W.
// STRUCTURE
//  - fir_alu_pkg: op encodings OP_ADD/OP_MUL/OP_MAC/OP_SUB as 2-bit localparams, plus
//    sat/truncate helper functions shared with the future fir_ctrl block.
//  - One sub-module, fir_alu_scale (ACC_W, OUT_W, OUT_SHIFT, SAT_EN): combinational
//    shift + saturate/truncate -> {result, out_sat}. Everything else lives in this module.
// TESTING (defaults unless noted; out_ready=1 unless noted)
//  1. ADD a=100,b=-30; SUB a=5,b=9; MUL a=300,b=-200 back-to-back -> results 70, -4, -60000
//     in cycles N+2..N+4, out_sat=0.
//  2. MAC a=1,2,3,4 with b=2 and in_last on the 4th beat -> exactly one beat, result=20; then
//     MAC a=1,b=1,last=1 -> result=1, confirming acc was cleared.
//  3. MAC 4x (a=-32768,b=-32768), last on the 4th -> sum 2^32 -> result=2147483647, out_sat=1.
//     Same stimulus with SAT_EN=0 -> result=0, out_sat=1.
//  4. Backpressure: stream 6 MUL beats and drop out_ready for 3 cycles after the first
//     out_valid -> in_ready=0 while stalled, result held stable, all 6 results arrive in order
//     with none lost or duplicated.
//  5. MAC a=10,b=10 (last=0), then ADD a=1,b=1, then MAC a=1,b=5 (last=1) -> outputs 2 then
//     105 (interleaving does not disturb acc).
//  6. Two MAC beats (last=0), assert rst for 1 cycle, then MAC a=3,b=3,last=1 -> single output
//     result=9, and out_valid=0 during and right after reset.

Source files
------------

// File: rtl/fir_alu_pkg.sv
// Op encodings and saturate/truncate helpers shared by the FIR arithmetic blocks.
// Helpers work on a 64-bit signed view, so callers sign-extend their value first.
package fir_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int HELPER_W = 64;

  // True when y is representable as a w-bit signed number.
  function automatic logic fits_signed(input logic signed [HELPER_W-1:0] y, input int w);
    logic signed [HELPER_W-1:0] hi;
    hi = y >>> (w - 1);
    return (hi == '0) || (&hi);
  endfunction

  function automatic logic signed [HELPER_W-1:0] sat_bound(input logic neg, input int w);
    logic signed [HELPER_W-1:0] mag;
    mag = 64'sd1;
    mag = mag <<< (w - 1);
    return neg ? -mag : mag - 64'sd1;
  endfunction

endpackage

// File: rtl/fir_alu_scale.sv
// Combinational output scaling: arithmetic shift, then clip or truncate to OUT_W.
// out_sat flags any value that does not fit, whichever mode is selected.
module fir_alu_scale
  import fir_alu_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0,
  parameter int SAT_EN    = 1
) (
  input  logic [ACC_W-1:0] x,
  output logic [OUT_W-1:0] result,
  output logic             out_sat
);

  logic signed [ACC_W-1:0]    y;
  logic signed [HELPER_W-1:0] y_ext;
  logic                       fits;
  logic [OUT_W-1:0]           bound;

  assign y      = $signed(x) >>> OUT_SHIFT;
  assign y_ext  = HELPER_W'(y);
  assign fits   = fits_signed(y_ext, OUT_W);
  assign bound  = OUT_W'(sat_bound(y[ACC_W-1], OUT_W));
  assign result = ((SAT_EN != 0) && !fits) ? bound : y[OUT_W-1:0];
  assign out_sat = !fits;

endmodule

// File: rtl/fir_mac_alu.sv
// Pipelined signed ADD/SUB/MUL/MAC unit with guard-bit accumulator; accept -> out_valid in 2 cycles.
// A result held against !out_ready freezes the whole pipe and drops in_ready.
module fir_mac_alu
  import fir_alu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0,
  parameter int SAT_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op_sel,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic              out_sat
);

  logic                    stall;
  logic                    s1_vld;
  logic                    s1_last;
  logic [1:0]              s1_op;
  logic signed [ACC_W-1:0] s1_term;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] mac_sum;
  logic signed [ACC_W-1:0] scale_in;
  logic [OUT_W-1:0]        scale_res;
  logic                    scale_sat;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign a_ext = ACC_W'($signed(a));
  assign b_ext = ACC_W'($signed(b));

  // ACC_W >= 2*DATA_W, so the truncated product is still exact.
  always_comb begin
    term = '0;
    case (op_sel)
      OP_ADD:  term = a_ext + b_ext;
      OP_SUB:  term = a_ext - b_ext;
      default: term = a_ext * b_ext;
    endcase
  end

  assign mac_sum  = acc + s1_term;
  assign scale_in = (s1_op == OP_MAC) ? mac_sum : s1_term;

  fir_alu_scale #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT),
    .SAT_EN   (SAT_EN)
  ) u_scale (
    .x      (scale_in),
    .result (scale_res),
    .out_sat(scale_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_op     <= OP_ADD;
      s1_last   <= 1'b0;
      s1_term   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_op   <= op_sel;
        s1_last <= in_last && (op_sel == OP_MAC);
        s1_term <= term;
      end
      out_valid <= 1'b0;
      if (s1_vld) begin
        if (s1_op == OP_MAC && !s1_last) begin
          acc <= mac_sum;
        end else begin
          out_valid <= 1'b1;
          result    <= scale_res;
          out_sat   <= scale_sat;
          // Closing a MAC sum clears acc so the next MAC starts fresh.
          if (s1_op == OP_MAC) acc <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_alu.sv
// Scoreboard bench for fir_mac_alu: a saturating and a truncating instance share stimulus,
// expected beats come from an arithmetic model and are popped by an output monitor.
module tb_fir_mac_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  op_sel = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, in_ready_t;
  logic        out_valid, out_valid_t;
  logic        out_sat, out_sat_t;
  logic [31:0] result, result_t;

  always #5 clk = ~clk;

  fir_mac_alu #(.DATA_W(16), .ACC_W(40), .OUT_W(32), .OUT_SHIFT(0), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op_sel(op_sel), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_sat(out_sat)
  );

  fir_mac_alu #(.DATA_W(16), .ACC_W(40), .OUT_W(32), .OUT_SHIFT(0), .SAT_EN(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .a(a), .b(b),
    .op_sel(op_sel), .in_last(in_last), .out_valid(out_valid_t), .out_ready(out_ready),
    .result(result_t), .out_sat(out_sat_t)
  );

  typedef struct {
    logic [31:0] res;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t   sb_s[$];
  exp_t   sb_t[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     lat_chk = 1'b1;
  bit     rnd_done = 1'b0;
  longint m_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 40-bit accumulator wrap, expressed as sign-extension of the low 40 bits.
  function automatic longint wrap_acc(input longint x);
    return (x <<< 24) >>> 24;
  endfunction

  task automatic push_exp(input longint v);
    exp_t        e;
    logic [63:0] vb;
    vb    = v;
    e.cyc = cyc;
    if (v > 64'sd2147483647) begin
      e.res = 32'h7fff_ffff; e.sat = 1'b1;
    end else if (v < -64'sd2147483648) begin
      e.res = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.res = vb[31:0]; e.sat = 1'b0;
    end
    sb_s.push_back(e);
    e.res = vb[31:0];
    e.sat = (longint'($signed(vb[31:0])) != v);
    sb_t.push_back(e);
  endtask

  task automatic model(input int op, input int xa, input int xb, input bit last);
    longint t;
    case (op)
      0:       t = longint'(xa) + longint'(xb);
      3:       t = longint'(xa) - longint'(xb);
      default: t = longint'(xa) * longint'(xb);
    endcase
    if (op == 2) begin
      m_acc = wrap_acc(m_acc + t);
      if (last) begin
        push_exp(m_acc);
        m_acc = 0;
      end
    end else begin
      push_exp(t);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input int op, input int xa, input int xb, input bit last);
    in_valid = 1'b1;
    op_sel   = 2'(op);
    a        = 16'(xa);
    b        = 16'(xb);
    in_last  = last;
    for (int i = 0; i < 64; i++) begin
      #3;
      if (in_ready && in_ready_t) begin
        model(op, xa, xb, last);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb_s.size() != 0 || sb_t.size() != 0); i++) @(negedge clk);
    check("drain_pending_beats", 64'(sb_s.size() + sb_t.size()), 64'd0);
  endtask

  function automatic int rnd_opnd();
    case ($urandom_range(5))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(65535)) - 32768;
    endcase
  endfunction

  // Output monitor, sampling 3ns after the negedge (well clear of the rising edge).
  bit          held_vld = 1'b0;
  logic [31:0] held_res = '0;
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_result_held", 64'(result), 64'(held_res));
      end
      if (out_valid && !out_ready) begin
        check("in_ready_while_stalled", 64'(in_ready), 64'd0);
        held_vld = 1'b1;
        held_res = result;
      end else begin
        held_vld = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb_s.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat_sat: got result 0x%0h, expected no beat", result);
        end else begin
          e = sb_s.pop_front();
          check("result_sat", 64'(result), 64'(e.res));
          check("out_sat_sat", 64'(out_sat), 64'(e.sat));
          if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (out_valid_t && out_ready) begin
        if (sb_t.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat_trunc: got result 0x%0h, expected no beat", result_t);
        end else begin
          e = sb_t.pop_front();
          check("result_trunc", 64'(result_t), 64'(e.res));
          check("out_sat_trunc", 64'(out_sat_t), 64'(e.sat));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_out_sat", 64'(out_sat), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid_trunc", 64'(out_valid_t), 64'd0);
    @(negedge clk);

    // ADD / SUB / MUL back to back: 70, -4, -60000
    send(0, 100, -30, 1'b0);
    send(3, 5, 9, 1'b0);
    send(1, 300, -200, 1'b0);
    idle(1);
    drain();

    // Dot product of {1,2,3,4} with 2 -> 20, then a fresh one-term sum -> 1
    for (int i = 1; i <= 4; i++) send(2, i, 2, i == 4);
    send(2, 1, 1, 1'b1);
    idle(1);
    drain();

    // Four max-magnitude products sum to 2^32: clipped / truncated to 0
    for (int i = 0; i < 4; i++) send(2, -32768, -32768, i == 3);
    idle(1);
    drain();

    // Backpressure: out_ready low for 3 cycles after the first result
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1, rnd_opnd(), rnd_opnd(), 1'b0);
        idle(1);
      end
      begin
        for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // ADD interleaved into an open MAC sum: 2 then 105
    send(2, 10, 10, 1'b0);
    send(0, 1, 1, 1'b0);
    send(2, 1, 5, 1'b1);
    idle(1);
    drain();

    // Reset in the middle of a MAC sum discards it
    send(2, 7, 9, 1'b0);
    send(2, -4, 100, 1'b0);
    idle(2);
    rst   = 1'b1;
    m_acc = 0;
    #3;
    check("out_valid_during_reset", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("out_valid_after_reset", 64'(out_valid), 64'd0);
    @(negedge clk);
    send(2, 3, 3, 1'b1);
    idle(1);
    drain();

    // Random traffic with random backpressure
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(7) == 0) idle(1);
          send(int'($urandom_range(3)), rnd_opnd(), rnd_opnd(), $urandom_range(3) == 0);
        end
        idle(1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
